model_share_arbiter: RTL and testbench
======================================

// Module: model_share_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one `model` datapath instance between NUM_REQ requesters.
//  - Grants one requester at a time.
//  - Drives the winner's operands onto model inputs i0[2:-2] and i1[-2:2].
//  - Waits a fixed LAT cycles, captures o0[2:-2] and o1[-2:2], returns them tagged with the requester id.
//  - Sits between requester logic and the single shared model instance in the top level.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8)
//  LAT      2  model response latency in clk cycles (1..15)
//  IDW      2  width of requester id (>= clog2(NUM_REQ))
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous, active-high reset
//  req        in   NUM_REQ    per-requester request; held until its gnt bit pulses
//  req_i0     in   5*NUM_REQ  requester k operand0 in [5k+4:5k]; bit 5k+4 -> i0[2], 5k -> i0[-2]
//  req_i1     in   5*NUM_REQ  requester k operand1 in [5k+4:5k]; bit 5k+4 -> i1[-2], 5k -> i1[2]
//  gnt        out  NUM_REQ    one-hot grant pulse (1 cycle)
//  m_i0       out  [2:-2]     to model i0
//  m_i1       out  [-2:2]     to model i1
//  m_valid    out  1          operands on m_i0/m_i1 are new this cycle
//  m_o0       in   [2:-2]     from model o0
//  m_o1       in   [-2:2]     from model o1
//  rsp_valid  out  1          response pulse (1 cycle)
//  rsp_id     out  IDW        id of requester owning the response
//  rsp_o0     out  [2:-2]     captured o0
//  rsp_o1     out  [-2:2]     captured o1
//  busy       out  1          high in every state except IDLE
// BEHAVIOUR
//  - All outputs are registered. Reset value of every output is 0; the round-robin pointer ptr resets to 0.
//  - FSM states: IDLE, ISSUE, WAIT, RESP.
//  - IDLE: if |req, the winner is the first set bit searching upward from ptr, with wrap at NUM_REQ-1 -> 0.
//    - Next cycle (ISSUE): gnt[w]=1, m_valid=1, m_i0/m_i1 loaded from winner's slices, cnt=LAT-1.
//    - No request: stay in IDLE.
//  - ISSUE -> WAIT.
//  - WAIT: cnt decrements each cycle; m_o0/m_o1 are sampled when cnt==0, i.e. LAT cycles after the ISSUE cycle.
//    - Then go to RESP.
//    - LAT=1: WAIT lasts exactly one cycle.
//  - RESP: rsp_valid=1 and rsp_id=w for one cycle; rsp_o0/rsp_o1 hold the sampled data.
//    - ptr <= (w+1) mod NUM_REQ. Next state is IDLE.
//  - Timing: ISSUE at cycle T gives RESP at T+LAT+1. The next ISSUE is no earlier than T+LAT+3.
//  - m_i0/m_i1 hold their values until the next ISSUE. rsp_* data holds until the next RESP.
//  - Bit mapping is positional: slice LSB -> rightmost declared index. No reversal is applied to ascending [-2:2] buses.
//  - A requester dropping req before its grant is skipped; there is no queuing.
//  - req changes outside IDLE are ignored until the FSM returns to IDLE.
//  - Simultaneous requests: strict round-robin order from ptr. A single requester may win back-to-back.
//  - rst in any state: FSM -> IDLE, ptr=0, all outputs 0. In-flight responses are discarded with no rsp_valid.
// CONFIGURATION
//  MODEL_SHARE_ARB_STATS_EN
//  - Defined: adds output port grant_cnt [16*NUM_REQ-1:0], one 16-bit counter per requester.
//    - Counter k increments on each gnt[k] and saturates at 16'hFFFF.
//    - Counters clear on rst.
//  - Undefined: the port and the counters are absent; all other behaviour is identical.
// TESTING
//  1. Reset: rst=1 for 2 cycles with req=4'b1111 -> all outputs 0, busy=0, no gnt.
//  2. Single request, LAT=2: req=0001, req_i0[4:0]=5'b10011, req_i1[4:0]=5'b00110 ->
//     - gnt=0001 and m_i0=5'b10011 (m_i0[2]=1, m_i0[-2]=1) at T, m_i1[-2:2]=00110.
//     - rsp_valid at T+3, rsp_id=0, rsp_o0/rsp_o1 equal model outputs at T+2.
//  3. Round-robin: req=1111 held -> grant order 0,1,2,3,0, with 5-cycle spacing at LAT=2.
//  4. Wrap: ptr=3, req=0101 -> gnt=0001 first, then 0100.
//  5. Reset mid-op: rst in WAIT -> no rsp_valid, busy=0 next cycle, next grant comes from ptr=0.
//  6. MODEL_SHARE_ARB_STATS_EN defined, 10 grants to requester 2 -> grant_cnt[47:32]=10, other counters 0.

Source files
------------

// File: rtl/model_share_arbiter_if.sv
// Requester-side and model-side handshake bundle for model_share_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface model_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [5*NUM_REQ-1:0] req_i0;
  logic [5*NUM_REQ-1:0] req_i1;
  logic [NUM_REQ-1:0]   gnt;
  logic [2:-2]          m_i0;
  logic [-2:2]          m_i1;
  logic                 m_valid;
  logic [2:-2]          m_o0;
  logic [-2:2]          m_o1;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [2:-2]          rsp_o0;
  logic [-2:2]          rsp_o1;
  logic                 busy;

  modport slave (
    input  req, req_i0, req_i1, m_o0, m_o1,
    output gnt, m_i0, m_i1, m_valid, rsp_valid, rsp_id, rsp_o0, rsp_o1, busy
  );

  modport master (
    output req, req_i0, req_i1, m_o0, m_o1,
    input  gnt, m_i0, m_i1, m_valid, rsp_valid, rsp_id, rsp_o0, rsp_o1, busy
  );
endinterface

// File: rtl/model_share_arbiter.sv
// Round-robin sequencer sharing one fixed-latency model datapath among NUM_REQ requesters.
// Optional per-requester grant counters are enabled with `define MODEL_SHARE_ARB_STATS_EN.
module model_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LAT     = 2,
  parameter int IDW     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  model_share_arbiter_if.slave  bus
`ifdef MODEL_SHARE_ARB_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0] grant_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Returns {hit, index} of the first set request at or above p, wrapping to 0.
  function automatic logic [IDW:0] pick_winner(input logic [NUM_REQ-1:0] r,
                                               input logic [IDW-1:0]     p);
    logic [IDW:0] res;
    int           idx;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(p) + i) % NUM_REQ;
      res = r[idx] ? {1'b1, IDW'(idx)} : res;
    end
    return res;
  endfunction

  state_t             state_r;
  logic [IDW-1:0]     ptr_r;
  logic [IDW-1:0]     win_r;
  logic [3:0]         cnt_r;
  logic [NUM_REQ-1:0] gnt_r;
  logic [2:-2]        m_i0_r;
  logic [-2:2]        m_i1_r;
  logic               m_valid_r;
  logic               rsp_valid_r;
  logic [IDW-1:0]     rsp_id_r;
  logic [2:-2]        rsp_o0_r;
  logic [-2:2]        rsp_o1_r;
  logic               busy_r;

  logic [IDW:0]       win_s;
  logic               win_hit_s;
  logic [IDW-1:0]     win_idx_s;

  // Round-robin search over the live request vector.
  always_comb begin
    win_s     = pick_winner(bus.req, ptr_r);
    win_hit_s = win_s[IDW];
    win_idx_s = win_s[IDW-1:0];
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= '0;
      win_r       <= '0;
      cnt_r       <= 4'd0;
      gnt_r       <= '0;
      m_i0_r      <= 5'd0;
      m_i1_r      <= 5'd0;
      m_valid_r   <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_o0_r    <= 5'd0;
      rsp_o1_r    <= 5'd0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (win_hit_s) begin
            state_r   <= ST_ISSUE;
            win_r     <= win_idx_s;
            gnt_r     <= NUM_REQ'(1'b1) << win_idx_s;
            m_valid_r <= 1'b1;
            m_i0_r    <= bus.req_i0[int'(win_idx_s)*5 +: 5];
            m_i1_r    <= bus.req_i1[int'(win_idx_s)*5 +: 5];
            cnt_r     <= 4'(LAT - 1);
            busy_r    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          gnt_r     <= '0;
          m_valid_r <= 1'b0;
          state_r   <= ST_WAIT;
        end
        ST_WAIT: begin
          // cnt reaches zero exactly LAT cycles after the ISSUE cycle.
          if (cnt_r == 4'd0) begin
            rsp_o0_r    <= bus.m_o0;
            rsp_o1_r    <= bus.m_o1;
            rsp_id_r    <= win_r;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          ptr_r       <= (win_r == IDW'(NUM_REQ - 1)) ? '0 : win_r + IDW'(1);
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          gnt_r       <= '0;
          m_valid_r   <= 1'b0;
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.m_i0      = m_i0_r;
  assign bus.m_i1      = m_i1_r;
  assign bus.m_valid   = m_valid_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_o0    = rsp_o0_r;
  assign bus.rsp_o1    = rsp_o1_r;
  assign bus.busy      = busy_r;

`ifdef MODEL_SHARE_ARB_STATS_EN
  logic [16*NUM_REQ-1:0] grant_cnt_r;

  // Saturating per-requester grant counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_r <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (gnt_r[k] && (grant_cnt_r[16*k +: 16] != 16'hFFFF)) begin
          grant_cnt_r[16*k +: 16] <= grant_cnt_r[16*k +: 16] + 16'd1;
        end
      end
    end
  end

  assign grant_cnt = grant_cnt_r;
`endif

endmodule

// File: tb/tb_model_share_arbiter.sv
// Scoreboard bench for model_share_arbiter (NUM_REQ=4, LAT=2): grants and operands checked
// against a round-robin reference, responses checked for id, data and exact cycle.
module tb_model_share_arbiter;
  localparam int NREQ = 4;
  localparam int LATV = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  model_share_arbiter_if #(.NUM_REQ(NREQ), .IDW(2)) ifc ();

`ifdef MODEL_SHARE_ARB_STATS_EN
  logic [16*NREQ-1:0] grant_cnt;
`endif

  model_share_arbiter #(.NUM_REQ(NREQ), .LAT(LATV), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifc)
`ifdef MODEL_SHARE_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in model whose outputs change every cycle, so the capture cycle is observable.
  function automatic logic [4:0] f0(input int c);
    logic [4:0] t;
    t = c[4:0];
    return t ^ 5'b10101;
  endfunction

  function automatic logic [4:0] f1(input int c);
    logic [4:0] t;
    t = c[4:0];
    return t + 5'd7;
  endfunction

  assign ifc.m_o0 = f0(cyc);
  assign ifc.m_o1 = f1(cyc);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    int idx;
    for (int i = 0; i < NREQ; i++) begin
      idx = (p + i) % NREQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  typedef struct {
    int         id;
    logic [4:0] o0;
    logic [4:0] o1;
    int         at;
  } exp_t;

  exp_t              sb[$];
  logic [NREQ-1:0]   req_prev = '0;
  logic [5*NREQ-1:0] i0_prev  = '0;
  logic [5*NREQ-1:0] i1_prev  = '0;
  int                exp_ptr  = 0;
  int                rsp_count = 0;

  // Monitor: predicts each grant, pushes its response, and scores responses.
  always @(negedge clk) begin
    int          w;
    exp_t        e;
    logic [31:0] eg;
    if (rst) begin
      sb.delete();
      exp_ptr = 0;
    end else begin
      if (ifc.m_valid || ifc.gnt != 4'd0)
        check("m_valid_with_gnt", 32'(ifc.m_valid), 32'(ifc.gnt != 4'd0));
      if (ifc.gnt != 4'd0) begin
        w  = rr_pick(req_prev, exp_ptr);
        eg = 32'd0;
        if (w >= 0) eg = 32'd1 << w;
        check("gnt_order", 32'(ifc.gnt), eg);
        if (w >= 0) begin
          check("m_i0_operand", 32'(ifc.m_i0), 32'(i0_prev[5*w +: 5]));
          check("m_i1_operand", 32'(ifc.m_i1), 32'(i1_prev[5*w +: 5]));
          check("busy_in_issue", 32'(ifc.busy), 32'd1);
          e.id = w;
          e.o0 = f0(cyc + LATV);
          e.o1 = f1(cyc + LATV);
          e.at = cyc + LATV + 1;
          sb.push_back(e);
        end
      end
      if (ifc.rsp_valid) begin
        rsp_count++;
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_id", 32'(ifc.rsp_id), 32'(e.id));
          check("rsp_o0", 32'(ifc.rsp_o0), 32'(e.o0));
          check("rsp_o1", 32'(ifc.rsp_o1), 32'(e.o1));
          check("rsp_cycle", 32'(cyc), 32'(e.at));
          check("busy_in_resp", 32'(ifc.busy), 32'd1);
          exp_ptr = (e.id + 1) % NREQ;
        end
      end
    end
    req_prev = ifc.req;
    i0_prev  = ifc.req_i0;
    i1_prev  = ifc.req_i1;
  end

  task automatic wait_any_gnt(output int id, output int gcyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ifc.gnt == 4'd0 && n < 40);
    check("gnt_seen", 32'(ifc.gnt != 4'd0), 32'd1);
    id = -1;
    for (int i = 0; i < NREQ; i++) if (ifc.gnt[i]) id = i;
    gcyc = cyc;
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (rsp_count < target && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rsp_seen", 32'(rsp_count >= target), 32'd1);
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk); #1;
    rst     = 1'b1;
    ifc.req = '0;
    repeat (ncyc) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive_req(input logic [NREQ-1:0] r);
    @(posedge clk); #1;
    ifc.req = r;
  endtask

  initial begin
    int id, gc, prev_gc, base;
    ifc.req    = 4'b1111;
    ifc.req_i0 = 20'($urandom);
    ifc.req_i1 = 20'($urandom);

    // Reset held two cycles with all requests active.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt",       32'(ifc.gnt),       32'd0);
    check("rst_m_valid",   32'(ifc.m_valid),   32'd0);
    check("rst_m_i0",      32'(ifc.m_i0),      32'd0);
    check("rst_m_i1",      32'(ifc.m_i1),      32'd0);
    check("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    check("rst_rsp_id",    32'(ifc.rsp_id),    32'd0);
    check("rst_rsp_o0",    32'(ifc.rsp_o0),    32'd0);
    check("rst_rsp_o1",    32'(ifc.rsp_o1),    32'd0);
    check("rst_busy",      32'(ifc.busy),      32'd0);
    @(posedge clk); #1;
    ifc.req = '0;
    rst     = 1'b0;

    // Single request with fixed operands and bit-mapping checks.
    base = rsp_count;
    @(posedge clk); #1;
    ifc.req_i0[4:0] = 5'b10011;
    ifc.req_i1[4:0] = 5'b00110;
    ifc.req         = 4'b0001;
    wait_any_gnt(id, gc);
    check("t2_id", 32'(id), 32'd0);
    check("t2_m_i0", 32'(ifc.m_i0), 32'h13);
    check("t2_m_i0_hi", 32'(ifc.m_i0[2]), 32'd1);
    check("t2_m_i0_lo", 32'(ifc.m_i0[-2]), 32'd1);
    check("t2_m_i1", 32'(ifc.m_i1), 32'h06);
    check("t2_m_i1_left", 32'(ifc.m_i1[-2]), 32'd0);
    check("t2_m_i1_idx1", 32'(ifc.m_i1[1]), 32'd1);
    drive_req(4'b0000);
    wait_rsp(base + 1);

    // All requesters held: order 0,1,2,3,0 with 5-cycle spacing.
    do_reset(1);
    base = rsp_count;
    ifc.req_i0 = 20'($urandom);
    ifc.req_i1 = 20'($urandom);
    drive_req(4'b1111);
    prev_gc = 0;
    for (int i = 0; i < 5; i++) begin
      wait_any_gnt(id, gc);
      check("t3_order", 32'(id), 32'(i % NREQ));
      if (i > 0) check("t3_spacing", 32'(gc - prev_gc), 32'd5);
      prev_gc = gc;
    end
    drive_req(4'b0000);
    wait_rsp(base + 5);

    // Wrap: bring ptr to 3, then requests 0 and 2.
    do_reset(1);
    base = rsp_count;
    ifc.req_i0 = 20'($urandom);
    ifc.req_i1 = 20'($urandom);
    drive_req(4'b0100);
    wait_any_gnt(id, gc);
    check("t4_prime", 32'(id), 32'd2);
    drive_req(4'b0000);
    wait_rsp(base + 1);
    drive_req(4'b0101);
    wait_any_gnt(id, gc);
    check("t4_wrap_first", 32'(id), 32'd0);
    drive_req(4'b0100);
    wait_any_gnt(id, gc);
    check("t4_wrap_second", 32'(id), 32'd2);
    drive_req(4'b0000);
    wait_rsp(base + 3);

    // Reset during WAIT: response dropped, ptr back to 0.
    drive_req(4'b0010);
    wait_any_gnt(id, gc);
    check("t5_first", 32'(id), 32'd1);
    @(posedge clk); #1;
    ifc.req = '0;
    rst     = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_busy_after_rst", 32'(ifc.busy), 32'd0);
    check("t5_gnt_after_rst",  32'(ifc.gnt),  32'd0);
    base = rsp_count;
    repeat (6) @(negedge clk);
    check("t5_no_rsp", 32'(rsp_count), 32'(base));
    drive_req(4'b1010);
    wait_any_gnt(id, gc);
    check("t5_ptr_zero", 32'(id), 32'd1);
    drive_req(4'b0000);
    wait_rsp(base + 1);

`ifdef MODEL_SHARE_ARB_STATS_EN
    // Ten grants to requester 2.
    do_reset(1);
    base = rsp_count;
    for (int i = 0; i < 10; i++) begin
      ifc.req_i0 = 20'($urandom);
      drive_req(4'b0100);
      wait_any_gnt(id, gc);
      drive_req(4'b0000);
      wait_rsp(base + i + 1);
    end
    @(negedge clk);
    check("t6_cnt2", 32'(grant_cnt[47:32]), 32'd10);
    check("t6_cnt0", 32'(grant_cnt[15:0]),  32'd0);
    check("t6_cnt1", 32'(grant_cnt[31:16]), 32'd0);
    check("t6_cnt3", 32'(grant_cnt[63:48]), 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("end_sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
